// File: rtl/biquad8_coeff_loader_pkg.sv
// biquad8_coeff_loader_pkg
//   Shared definitions for the biquad8 coefficient loader and its shadow RAM:
//   address/data widths, default chain lengths, the DSP data-latch delay and
//   the FSM state encoding.
//   Optional feature macro used by the files importing this package:
//   COEFF_READBACK_EN (host readback through a second shadow read port).
package biquad8_coeff_loader_pkg;

  localparam int ADR_W = 5;   // [4] chain select (0=F, 1=G), [3:0] DSP index
  localparam int IDX_W = 4;
  localparam int DAT_W = 18;  // Q4.14 coefficient
  localparam int DEPTH = 32;

  localparam int DEF_F_TAPS    = 7;
  localparam int DEF_G_TAPS    = 8;
  localparam int DEF_DAT_DELAY = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_FX = 3'd1,
    ST_LOAD_FC = 3'd2,
    ST_LOAD_GX = 3'd3,
    ST_LOAD_GC = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  function automatic logic [ADR_W-1:0] mk_adr(input logic chain, input logic [IDX_W-1:0] idx);
    return {chain, idx};
  endfunction

endpackage

// File: rtl/biquad8_coeff_loader_shadow.sv
// biquad8_coeff_loader_shadow
//   32x18 shadow coefficient table. Synchronous write, registered read port A
//   (used by the replay engine); registered read port B only when
//   COEFF_READBACK_EN is defined (host readback).
//   The array itself is not reset; only the read registers are.
// Ports
//   clk, rst_n     clock, async active-low reset (read registers only)
//   we, wadr, wdat write port
//   adr_a, q_a     read port A, 1-cycle latency
//   adr_b, q_b     read port B, 1-cycle latency (COEFF_READBACK_EN only)
module biquad8_coeff_loader_shadow
  import biquad8_coeff_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ADR_W-1:0] wadr,
  input  logic [DAT_W-1:0] wdat,
  input  logic [ADR_W-1:0] adr_a,
  output logic [DAT_W-1:0] q_a
`ifdef COEFF_READBACK_EN
  ,
  input  logic [ADR_W-1:0] adr_b,
  output logic [DAT_W-1:0] q_b
`endif
);

  logic [DAT_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdat;
  end

  // Read-during-write returns the old word; the replay never reads in the
  // write cycle, so the same-cycle commit+write case still sees the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_a <= '0;
    else        q_a <= mem[adr_a];
  end

`ifdef COEFF_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_b <= '0;
    else        q_b <= mem[adr_b];
  end
`endif

endmodule

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader
//   Host-side driver for the biquad8 pole-FIR coefficient port. The host fills
//   a shadow table; a commit replays it into the F and G B-cascade chains
//   (cross DSP first, then the cascade head, data from the top index down to
//   0) and ends with a single coeff_update pulse so all DSPs swap together.
//   Optional feature: COEFF_READBACK_EN adds host_rdat_o (registered readback
//   of shadow[host_adr_i], valid during replay).
// Ports
//   clk, rst_n                 clock, async active-low reset
//   host_adr_i/dat_i/wr_i      shadow write port ([4]=chain, [3:0]=index)
//   host_commit_i              request a replay
//   busy_o, done_o, err_o      replay status; err_o is sticky (write while busy)
//   coeff_adr_o/wr_o/dat_o     to pole FIR; dat lags wr by DAT_DELAY cycles
//   coeff_update_o             one-cycle swap strobe to pole FIR
//   host_rdat_o                readback (COEFF_READBACK_EN only)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a commit
// ST_LOAD_FX | read F cross coefficient; its write appears next cycle
// ST_LOAD_FC | read F[idx], idx F_TAPS-1..0, written to the F cascade head
// ST_LOAD_GX | read G cross coefficient
// ST_LOAD_GC | read G[idx], idx G_TAPS-1..0, written to the G cascade head
// ST_DRAIN   | wait out the last write and its DAT_DELAY data latency
// ST_UPDATE  | coeff_update_o high
// ST_DONE    | done_o high, busy_o low; a pending/new commit restarts here
module biquad8_coeff_loader
  import biquad8_coeff_loader_pkg::*;
#(
  parameter int F_TAPS    = DEF_F_TAPS,
  parameter int G_TAPS    = DEF_G_TAPS,
  parameter int DAT_DELAY = DEF_DAT_DELAY  // must be >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADR_W-1:0] host_adr_i,
  input  logic [DAT_W-1:0] host_dat_i,
  input  logic             host_wr_i,
  input  logic             host_commit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [ADR_W-1:0] coeff_adr_o,
  output logic             coeff_wr_o,
  output logic             coeff_update_o,
  output logic [DAT_W-1:0] coeff_dat_o
`ifdef COEFF_READBACK_EN
  ,
  output logic [DAT_W-1:0] host_rdat_o
`endif
);

  state_t           state;
  logic [IDX_W-1:0] idx;       // shared down-counter: tap index, then drain timer
  logic             pending;
  logic             idle_like;
  logic             accept;
  logic             shadow_we;
  logic [ADR_W-1:0] rd_adr;
  logic [DAT_W-1:0] ram_q;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = idle_like && (host_commit_i || pending);
  assign shadow_we = host_wr_i && !busy_o;

  biquad8_coeff_loader_shadow u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (shadow_we),
    .wadr  (host_adr_i),
    .wdat  (host_dat_i),
    .adr_a (rd_adr),
    .q_a   (ram_q)
`ifdef COEFF_READBACK_EN
    ,
    .adr_b (host_adr_i),
    .q_b   (host_rdat_o)
`endif
  );

  // Read address is issued one cycle ahead of the matching coeff_wr_o so the
  // registered RAM output lines up with the write strobe.
  always_comb begin
    rd_adr = mk_adr(1'b0, idx);
    case (state)
      ST_LOAD_FX: rd_adr = mk_adr(1'b0, IDX_W'(F_TAPS));
      ST_LOAD_FC: rd_adr = mk_adr(1'b0, idx);
      ST_LOAD_GX: rd_adr = mk_adr(1'b1, IDX_W'(G_TAPS));
      ST_LOAD_GC: rd_adr = mk_adr(1'b1, idx);
      default:    rd_adr = mk_adr(1'b0, idx);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      pending        <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      coeff_adr_o    <= '0;
    end else begin
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      done_o         <= 1'b0;

      if (host_wr_i && busy_o) err_o <= 1'b1;
      // Commits during a replay collapse into a single pending request.
      if (host_commit_i && !idle_like) pending <= 1'b1;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state   <= ST_LOAD_FX;
            busy_o  <= 1'b1;
            pending <= 1'b0;
            err_o   <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_LOAD_FX: begin
          coeff_wr_o  <= 1'b1;
          coeff_adr_o <= mk_adr(1'b0, IDX_W'(F_TAPS));
          idx         <= IDX_W'(F_TAPS - 1);
          state       <= ST_LOAD_FC;
        end

        ST_LOAD_FC: begin
          coeff_wr_o  <= 1'b1;
          coeff_adr_o <= mk_adr(1'b0, IDX_W'(F_TAPS - 1));
          if (idx == '0) state <= ST_LOAD_GX;
          else           idx   <= idx - 1'b1;
        end

        ST_LOAD_GX: begin
          coeff_wr_o  <= 1'b1;
          coeff_adr_o <= mk_adr(1'b1, IDX_W'(G_TAPS));
          idx         <= IDX_W'(G_TAPS - 1);
          state       <= ST_LOAD_GC;
        end

        ST_LOAD_GC: begin
          coeff_wr_o  <= 1'b1;
          coeff_adr_o <= mk_adr(1'b1, IDX_W'(G_TAPS - 1));
          if (idx == '0) begin
            state <= ST_DRAIN;
            // DAT_DELAY+1 state cycles: the state leads the write strobe by
            // one, so this covers the last write plus its data latency.
            idx   <= IDX_W'(DAT_DELAY);
          end else begin
            idx <= idx - 1'b1;
          end
        end

        ST_DRAIN: begin
          if (idx == '0) begin
            state          <= ST_UPDATE;
            coeff_update_o <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        ST_UPDATE: begin
          state  <= ST_DONE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Data pipe: RAM word is aligned with coeff_wr_o; coeff_dat_o presents it
  // DAT_DELAY cycles later and holds between writes.
  logic [DAT_DELAY-2:0] vld_pipe;
  logic [DAT_W-1:0]     dat_pipe [0:DAT_DELAY-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      coeff_dat_o <= '0;
      for (int i = 0; i < DAT_DELAY - 1; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= coeff_wr_o;
      dat_pipe[0] <= ram_q;
      for (int i = 1; i < DAT_DELAY - 1; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
      if (vld_pipe[DAT_DELAY-2]) coeff_dat_o <= dat_pipe[DAT_DELAY-2];
    end
  end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
module tb_biquad8_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  host_adr_i = '0;
  logic [17:0] host_dat_i = '0;
  logic        host_wr_i = 1'b0;
  logic        host_commit_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [4:0]  coeff_adr_o;
  logic        coeff_wr_o, coeff_update_o;
  logic [17:0] coeff_dat_o;
`ifdef COEFF_READBACK_EN
  logic [17:0] host_rdat_o;
`endif

  biquad8_coeff_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_adr_i     (host_adr_i),
    .host_dat_i     (host_dat_i),
    .host_wr_i      (host_wr_i),
    .host_commit_i  (host_commit_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .coeff_adr_o    (coeff_adr_o),
    .coeff_wr_o     (coeff_wr_o),
    .coeff_update_o (coeff_update_o),
    .coeff_dat_o    (coeff_dat_o)
`ifdef COEFF_READBACK_EN
    ,
    .host_rdat_o    (host_rdat_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Event logs, filled at the falling edge.
  int          wr_cyc_q[$];
  logic [4:0]  wr_adr_q[$];
  logic [17:0] dat_q[$];
  int          upd_q[$];
  int          done_q[$];
  int          busy_rise_q[$];

  logic        wr_d1 = 1'b0, wr_d2 = 1'b0, busy_d = 1'b0;
  logic [4:0]  adr_d1 = '0, adr_d2 = '0;

  // Pole-FIR DSP model: chain writes shift the cascade (entry at DSP 0),
  // the cross DSP loads only when addressed; B1 samples DAT_DELAY=2 cycles
  // after the strobe, B2 takes B1 on update.
  logic [17:0] f_b1[0:7], f_b2[0:7];
  logic [17:0] g_b1[0:8], g_b2[0:8];

  always @(negedge clk) begin
    if (!rst_n) begin
      wr_d1  <= 1'b0;
      wr_d2  <= 1'b0;
      busy_d <= 1'b0;
    end else begin
      if (coeff_wr_o) begin
        wr_cyc_q.push_back(cyc);
        wr_adr_q.push_back(coeff_adr_o);
      end
      if (wr_d2) begin
        dat_q.push_back(coeff_dat_o);
        if (!adr_d2[4]) begin
          if (adr_d2[3:0] == 4'd7) f_b1[7] <= coeff_dat_o;
          f_b1[0] <= coeff_dat_o;
          for (int k = 1; k < 7; k++) f_b1[k] <= f_b1[k-1];
        end else begin
          if (adr_d2[3:0] == 4'd8) g_b1[8] <= coeff_dat_o;
          g_b1[0] <= coeff_dat_o;
          for (int k = 1; k < 8; k++) g_b1[k] <= g_b1[k-1];
        end
      end
      wr_d1  <= coeff_wr_o;
      adr_d1 <= coeff_adr_o;
      wr_d2  <= wr_d1;
      adr_d2 <= adr_d1;
      if (coeff_update_o) begin
        upd_q.push_back(cyc);
        for (int k = 0; k < 8; k++) f_b2[k] <= f_b1[k];
        for (int k = 0; k < 9; k++) g_b2[k] <= g_b1[k];
      end
      if (done_o) done_q.push_back(cyc);
      if (busy_o && !busy_d) busy_rise_q.push_back(cyc);
      busy_d <= busy_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cyc_q.delete(); wr_adr_q.delete(); dat_q.delete();
    upd_q.delete(); done_q.delete(); busy_rise_q.delete();
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_at(input int n);
    int k = 0;
    while (cyc < n && k < 200) begin next_cyc(); k++; end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [17:0] d);
    host_adr_i = a; host_dat_i = d; host_wr_i = 1'b1;
    next_cyc();
    host_wr_i = 1'b0;
  endtask

  task automatic do_commit(output int t);
    host_commit_i = 1'b1;
    t = cyc;
    next_cyc();
    host_commit_i = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_q.size() < n && k < 80) begin next_cyc(); k++; end
    chk("done_count", done_q.size(), n);
  endtask

  function automatic logic [4:0] exp_adr(input int i);
    if (i == 0)     return 5'd7;
    else if (i < 8) return 5'd6;
    else if (i == 8) return 5'd24;
    else            return 5'd23;
  endfunction

  function automatic logic [17:0] exp_dat(input int i);
    if (i == 0)      return 18'h107;
    else if (i < 8)  return 18'(18'h106 - (i - 1));
    else if (i == 8) return 18'h208;
    else             return 18'(18'h207 - (i - 9));
  endfunction

  // Replay number n (0-based within current logs) accepted at cycle t.
  task automatic check_seq(input string nm, input int t, input int n);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("%s wr_cyc[%0d]", nm, i), wr_cyc_q[17*n+i], t + 2 + i);
      chk($sformatf("%s wr_adr[%0d]", nm, i), wr_adr_q[17*n+i], exp_adr(i));
      chk($sformatf("%s dat[%0d]", nm, i), dat_q[17*n+i], exp_dat(i));
    end
    chk({nm, " update_cyc"}, upd_q[n], t + 21);
    chk({nm, " done_cyc"}, done_q[n], t + 22);
    chk({nm, " busy_rise"}, busy_rise_q[n], t + 1);
  endtask

  initial begin
    int t, t2;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("reset_outputs", {busy_o, done_o, err_o, coeff_wr_o, coeff_update_o, coeff_adr_o, coeff_dat_o}, 0);
    rst_n = 1'b1;
    next_cyc();

    // Fill the shadow table
    for (int k = 0; k < 8; k++) host_write(5'(k), 18'(18'h100 + k));
    for (int k = 0; k < 9; k++) host_write(5'(16 + k), 18'(18'h200 + k));
    chk("idle_no_wr", wr_cyc_q.size(), 0);

    // Test 1: basic replay
    clear_logs();
    do_commit(t);
    wait_done(1);
    check_seq("t1", t, 0);
    chk("t1 wr_count", wr_cyc_q.size(), 17);

    // Test 2: DSP model holds coefficient k
    for (int k = 0; k < 8; k++) chk($sformatf("t2 F_B2[%0d]", k), f_b2[k], 18'h100 + k);
    for (int k = 0; k < 9; k++) chk($sformatf("t2 G_B2[%0d]", k), g_b2[k], 18'h200 + k);

    // Test 3: two commits while busy merge into one extra replay
    next_cyc();
    clear_logs();
    do_commit(t);
    do_at(t + 5);
    host_commit_i = 1'b1; next_cyc(); host_commit_i = 1'b0;
    do_at(t + 9);
    host_commit_i = 1'b1; next_cyc(); host_commit_i = 1'b0;
    wait_done(2);
    repeat (30) next_cyc();
    chk("t3 last_wr_first", wr_cyc_q[16], t + 18);
    chk("t3 first_wr_second", wr_cyc_q[17], t + 24);
    check_seq("t3a", t, 0);
    check_seq("t3b", t + 22, 1);
    chk("t3 wr_count", wr_cyc_q.size(), 34);
    chk("t3 done_count_final", done_q.size(), 2);

    // Test 4: write while busy is dropped and flags err_o
    clear_logs();
    do_commit(t);
    do_at(t + 6);
    chk("t4 err_before", err_o, 0);
    host_adr_i = 5'd3; host_dat_i = 18'h3FFFF; host_wr_i = 1'b1;
    next_cyc();
    host_wr_i = 1'b0;
    chk("t4 err_set", err_o, 1);
    wait_done(1);
    chk("t4 err_sticky", err_o, 1);
    next_cyc();
    clear_logs();
    do_commit(t2);
    chk("t4 err_cleared", err_o, 0);
    wait_done(1);
    chk("t4 dat_F3", dat_q[4], 18'h103);
    check_seq("t4", t2, 0);
    chk("t4 F_B2[3]", f_b2[3], 18'h103);

    // Test 5: reset mid-replay
    clear_logs();
    do_commit(t);
    do_at(t + 10);
    chk("t5 wr_before_reset", coeff_wr_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t5 reset_outputs", {busy_o, done_o, err_o, coeff_wr_o, coeff_update_o, coeff_adr_o, coeff_dat_o}, 0);
    repeat (2) next_cyc();
    rst_n = 1'b1;
    clear_logs();
    repeat (12) next_cyc();
    chk("t5 no_wr_after_reset", wr_cyc_q.size(), 0);
    chk("t5 busy_after_reset", busy_o, 0);
    clear_logs();
    do_commit(t);
    wait_done(1);
    check_seq("t5", t, 0);

`ifdef COEFF_READBACK_EN
    // Test 6: readback
    host_write(5'd17, 18'h2ABCD);
    next_cyc();
    chk("t6 rdat_idle", host_rdat_o, 18'h2ABCD);
    clear_logs();
    do_commit(t);
    host_adr_i = 5'd5;
    next_cyc();
    chk("t6 busy", busy_o, 1);
    chk("t6 rdat_replay", host_rdat_o, 18'h105);
    wait_done(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
